pic_bus_sequencer: RTL and testbench
====================================

Name: pic_bus_sequencer

Overview:
Host-side controller for the PIC top block. It runs the ICW1–ICW4 and OCW1 initialisation sequence over the PIC's CS/WR/RD/A0/D bus, and forwards run-time OCW writes once initialisation is done. It also generates the two-pulse INTA acknowledge and captures the interrupt vector. It is the only master of the PIC bus pins and arbitrates between acknowledge cycles and OCW requests.

Parameters:
SETUP_CYC, 1, cycles with CS low, A0/D valid, strobe inactive, before the strobe asserts (min 1)
PULSE_CYC, 2, WR/RD low width, also INTA high width (min 1)
HOLD_CYC, 1, cycles after the strobe deasserts with CS still low and D still driven (min 1)
INTA_GAP, 2, INTA low cycles between the two pulses and after the second pulse (min 1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; latch icw1..ocw1 and begin init; ignored while busy
icw1/icw2/icw3/icw4/ocw1  in  8 each  init words
ocw_req  in  1  run-time write request; held until ocw_ack
ocw_a0  in  1  A0 value for the request
ocw_data  in  8  data byte for the request
ocw_ack  out  1  one-cycle pulse, request consumed
ack_en  in  1  enables automatic INTA sequencing
int_in  in  1  PIC INT output
vec  out  8  captured vector
vec_valid  out  1  one-cycle pulse when vec updates
busy  out  1  sequence or bus cycle in progress
init_done  out  1  init sequence completed
cfg_err  out  1  sticky error flag
CS/WR/RD  out  1 each  active-low PIC strobes
A0  out  1  PIC address bit
INTA  out  1  acknowledge to PIC, asserted high
D_out  out  8  write data
D_oe  out  1  drive enable for D_out onto the tristate bus
D_in  in  8  sampled bus data

Behaviour:
- Reset values: CS=WR=RD=1; A0=0; INTA=0; D_out=0; D_oe=0; busy=0; init_done=0; cfg_err=0; vec=0; vec_valid=0; ocw_ack=0. Reset asserted mid-operation aborts the current cycle, and pins return to these values at the next edge.
- Write cycle FSM: B_IDLE → B_SETUP (CS=0, A0/D_out valid, D_oe=1, SETUP_CYC cycles) → B_STROBE (WR=0, PULSE_CYC cycles) → B_HOLD (WR=1, CS=0, D_oe=1, HOLD_CYC cycles) → B_REL (CS=1, D_oe=0, 1 cycle) → B_IDLE. One write takes SETUP_CYC+PULSE_CYC+HOLD_CYC+1 cycles, which is 5 at the defaults.
- Init FSM: S_IDLE → S_ICW1 (A0=0, data icw1 with bit4 forced to 1) → S_ICW2 (A0=1) → S_ICW3 (A0=1, only if icw1[1]=0) → S_ICW4 (A0=1, only if icw1[0]=1) → S_OCW1 (A0=1) → S_RUN.
- Init timing: start is sampled at edge k. busy=1 and init_done=0 from cycle k+1. The first B_SETUP is cycle k+1. Consecutive writes are back to back. In the cycle after the last B_REL, busy=0 and init_done=1.
- A start pulse in S_RUN restarts init: init_done drops, cfg_err clears, and new words are latched.
- S_RUN arbitration, evaluated only when the bus is idle:
  - INTA sequence (init_done & ack_en & int_in) wins over ocw_req.
  - ocw_req is not serviced before init_done. It stays pending, with no ack.
  - OCW write: one bus cycle with ocw_a0/ocw_data. ocw_ack pulses in its B_REL cycle.
- OCW with ocw_a0=0 and ocw_data[4]=1 (ICW1 encoding) is rejected: no bus cycle, ocw_ack pulses the next cycle, cfg_err is set.
- INTA sequence:
  - INTA high for PULSE_CYC, low for INTA_GAP, high for PULSE_CYC.
  - D_in is sampled on the last cycle of the second pulse into vec. vec_valid pulses the following cycle.
  - INTA then stays low INTA_GAP cycles before int_in is re-evaluated.
  - busy=1 throughout. CS stays 1 and D_oe=0 during INTA.
- If int_in drops mid-sequence, the sequence still completes. vec reflects whatever D_in holds.

Optional Feature:
PIC_READBACK_EN:
- Defined: after the OCW1 write in init, one read cycle runs (same FSM, RD strobes in place of WR, A0=1, D_oe=0). D_in is sampled on the last B_STROBE cycle. A mismatch with ocw1 sets cfg_err. This adds 5 cycles at the defaults.
- Undefined: no read cycle, and RD stays 1 permanently.

Test Plan:
- Reset, then start with icw1=0x1B, icw2=0xA8, icw4=0x02, ocw1=0x80 → four writes with A0 = 0,1,1,1 and D = 1B,A8,02,80. WR is low 2 cycles each. init_done rises 21 cycles after the start edge. ICW3 is skipped.
- icw1=0x19, icw3=0x02 → five writes including ICW3=0x02. init_done rises at start+26.
- init_done, ack_en=1, int_in=1, with the bench driving D_in=0xAB on the second pulse → INTA pattern 1,1,0,0,1,1. vec=0xAB and vec_valid pulses once.
- int_in and ocw_req(a0=1, data 0x55) rise in the same cycle → the INTA sequence runs first, then the OCW write. ocw_ack pulses exactly once.
- ocw_req with a0=0, data 0x10 → no CS activity, ocw_ack next cycle, cfg_err=1. A following start clears cfg_err.
- Reset asserted during B_STROBE of ICW2 → WR=CS=1, D_oe=0, busy=0 next cycle. A new start replays from ICW1.

Source files
------------

// File: rtl/pic_bus_sequencer.sv
// Host-side bus master for the PIC: ICW1-ICW4/OCW1 init writes, run-time OCW writes, INTA acknowledge.
// Build option PIC_READBACK_EN adds an RD cycle after OCW1 that checks the mask readback.
module pic_bus_sequencer #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int INTA_GAP  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] icw1,
    input  logic [7:0] icw2,
    input  logic [7:0] icw3,
    input  logic [7:0] icw4,
    input  logic [7:0] ocw1,
    input  logic       ocw_req,
    input  logic       ocw_a0,
    input  logic [7:0] ocw_data,
    output logic       ocw_ack,
    input  logic       ack_en,
    input  logic       int_in,
    output logic [7:0] vec,
    output logic       vec_valid,
    output logic       busy,
    output logic       init_done,
    output logic       cfg_err,
    output logic       CS,
    output logic       WR,
    output logic       RD,
    output logic       A0,
    output logic       INTA,
    output logic [7:0] D_out,
    output logic       D_oe,
    input  logic [7:0] D_in,
    output logic [6:0] dbg_state
);
    // ocw_req/ocw_ack: the requester holds ocw_req with stable ocw_a0/ocw_data until ocw_ack
    // pulses for one cycle; a request is only taken when the bus is idle after init.
    typedef enum logic [2:0] {S_IDLE, S_ICW1, S_ICW2, S_ICW3, S_ICW4, S_OCW1, S_READ, S_RUN} init_t;
    typedef enum logic [3:0] {B_IDLE, B_SETUP, B_STROBE, B_HOLD, B_REL,
                              B_INTA1, B_IGAP1, B_INTA2, B_IGAP2} bus_t;

    localparam logic [7:0] SETUP_L = 8'(SETUP_CYC - 1);
    localparam logic [7:0] PULSE_L = 8'(PULSE_CYC - 1);
    localparam logic [7:0] HOLD_L  = 8'(HOLD_CYC - 1);
    localparam logic [7:0] GAP_L   = 8'(INTA_GAP - 1);

    init_t      istate, nxt_istate;
    bus_t       bstate;
    logic [7:0] cnt;
    logic [7:0] icw1_q, icw2_q, icw3_q, icw4_q, ocw1_q;
    logic       cur_ocw, cur_rd;
    logic       nxt_a0, nxt_rd;
    logic [7:0] nxt_data;

    assign dbg_state = {istate, bstate};

    // Next init step after the current write, and the word it puts on the bus.
    always_comb begin
        nxt_istate = S_RUN;
        nxt_a0     = 1'b1;
        nxt_data   = 8'h00;
        nxt_rd     = 1'b0;
        case (istate)
            S_ICW1:  nxt_istate = S_ICW2;
            S_ICW2:  nxt_istate = !icw1_q[1] ? S_ICW3 : (icw1_q[0] ? S_ICW4 : S_OCW1);
            S_ICW3:  nxt_istate = icw1_q[0] ? S_ICW4 : S_OCW1;
            S_ICW4:  nxt_istate = S_OCW1;
`ifdef PIC_READBACK_EN
            S_OCW1:  nxt_istate = S_READ;
`else
            S_OCW1:  nxt_istate = S_RUN;
`endif
            default: nxt_istate = S_RUN;
        endcase
        case (nxt_istate)
            S_ICW2:  nxt_data = icw2_q;
            S_ICW3:  nxt_data = icw3_q;
            S_ICW4:  nxt_data = icw4_q;
            S_OCW1:  nxt_data = ocw1_q;
            S_READ:  nxt_rd   = 1'b1;
            default: nxt_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            istate    <= S_IDLE;
            bstate    <= B_IDLE;
            cnt       <= 8'd0;
            icw1_q    <= 8'h00;
            icw2_q    <= 8'h00;
            icw3_q    <= 8'h00;
            icw4_q    <= 8'h00;
            ocw1_q    <= 8'h00;
            cur_ocw   <= 1'b0;
            cur_rd    <= 1'b0;
            CS        <= 1'b1;
            WR        <= 1'b1;
            RD        <= 1'b1;
            A0        <= 1'b0;
            INTA      <= 1'b0;
            D_out     <= 8'h00;
            D_oe      <= 1'b0;
            busy      <= 1'b0;
            init_done <= 1'b0;
            cfg_err   <= 1'b0;
            vec       <= 8'h00;
            vec_valid <= 1'b0;
            ocw_ack   <= 1'b0;
        end else begin
            ocw_ack   <= 1'b0;
            vec_valid <= 1'b0;
            case (bstate)
                B_IDLE: begin
                    if (start) begin
                        icw1_q    <= icw1;
                        icw2_q    <= icw2;
                        icw3_q    <= icw3;
                        icw4_q    <= icw4;
                        ocw1_q    <= ocw1;
                        istate    <= S_ICW1;
                        init_done <= 1'b0;
                        cfg_err   <= 1'b0;
                        bstate    <= B_SETUP;
                        cnt       <= SETUP_L;
                        CS        <= 1'b0;
                        A0        <= 1'b0;
                        D_out     <= icw1 | 8'h10;
                        D_oe      <= 1'b1;
                        busy      <= 1'b1;
                        cur_ocw   <= 1'b0;
                        cur_rd    <= 1'b0;
                    end else if (istate == S_RUN) begin
                        if (ack_en && int_in) begin
                            bstate <= B_INTA1;
                            cnt    <= PULSE_L;
                            INTA   <= 1'b1;
                            busy   <= 1'b1;
                        end else if (ocw_req && !ocw_ack) begin
                            // An ICW1-shaped word would re-init the PIC behind our back.
                            if (!ocw_a0 && ocw_data[4]) begin
                                ocw_ack <= 1'b1;
                                cfg_err <= 1'b1;
                            end else begin
                                bstate  <= B_SETUP;
                                cnt     <= SETUP_L;
                                CS      <= 1'b0;
                                A0      <= ocw_a0;
                                D_out   <= ocw_data;
                                D_oe    <= 1'b1;
                                busy    <= 1'b1;
                                cur_ocw <= 1'b1;
                                cur_rd  <= 1'b0;
                            end
                        end
                    end
                end
                B_SETUP: begin
                    if (cnt == 8'd0) begin
                        bstate <= B_STROBE;
                        cnt    <= PULSE_L;
                        if (cur_rd) RD <= 1'b0;
                        else        WR <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                B_STROBE: begin
                    if (cnt == 8'd0) begin
                        bstate <= B_HOLD;
                        cnt    <= HOLD_L;
                        WR     <= 1'b1;
                        RD     <= 1'b1;
                        if (cur_rd && (D_in != ocw1_q)) cfg_err <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                B_HOLD: begin
                    if (cnt == 8'd0) begin
                        bstate  <= B_REL;
                        CS      <= 1'b1;
                        D_oe    <= 1'b0;
                        ocw_ack <= cur_ocw;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                B_REL: begin
                    if (nxt_istate != S_RUN) begin
                        istate <= nxt_istate;
                        bstate <= B_SETUP;
                        cnt    <= SETUP_L;
                        CS     <= 1'b0;
                        A0     <= nxt_a0;
                        D_out  <= nxt_data;
                        D_oe   <= !nxt_rd;
                        cur_rd <= nxt_rd;
                    end else begin
                        istate    <= S_RUN;
                        bstate    <= B_IDLE;
                        busy      <= 1'b0;
                        init_done <= 1'b1;
                        cur_ocw   <= 1'b0;
                        cur_rd    <= 1'b0;
                    end
                end
                B_INTA1: begin
                    if (cnt == 8'd0) begin
                        bstate <= B_IGAP1;
                        cnt    <= GAP_L;
                        INTA   <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                B_IGAP1: begin
                    if (cnt == 8'd0) begin
                        bstate <= B_INTA2;
                        cnt    <= PULSE_L;
                        INTA   <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                B_INTA2: begin
                    if (cnt == 8'd0) begin
                        bstate    <= B_IGAP2;
                        cnt       <= GAP_L;
                        INTA      <= 1'b0;
                        vec       <= D_in;
                        vec_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                B_IGAP2: begin
                    if (cnt == 8'd0) begin
                        bstate <= B_IDLE;
                        busy   <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: bstate <= B_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pic_bus_sequencer.sv
// Bench for pic_bus_sequencer: directed steps with randomized words, checked against a
// transaction-level model of the init/OCW/INTA rules.
module tb_pic_bus_sequencer;
    localparam int SETUP_CYC = 1;
    localparam int PULSE_CYC = 2;
    localparam int HOLD_CYC  = 1;
    localparam int INTA_GAP  = 2;
    localparam int WR_LEN    = SETUP_CYC + PULSE_CYC + HOLD_CYC + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] icw1 = 8'h00, icw2 = 8'h00, icw3 = 8'h00, icw4 = 8'h00, ocw1 = 8'h00;
    logic       ocw_req = 1'b0;
    logic       ocw_a0 = 1'b0;
    logic [7:0] ocw_data = 8'h00;
    logic       ocw_ack;
    logic       ack_en = 1'b0;
    logic       int_in = 1'b0;
    logic [7:0] vec;
    logic       vec_valid, busy, init_done, cfg_err;
    logic       CS, WR, RD, A0, INTA, D_oe;
    logic [7:0] D_out;
    logic [7:0] D_in = 8'h00;
    logic [6:0] dbg_state;

    int vectors = 0;
    int miscompares = 0;

    // Bus transactions as {CS, D_oe, A0, D}, captured on the first WR-low cycle.
    logic [10:0] exp_q[$];
    logic [10:0] act_q[$];
    int          wid_q[$];
    int          cs_falls = 0;
    int          rd_lows = 0;
    int          wr_low_cnt = 0;
    logic        wr_prev = 1'b1, cs_prev = 1'b1;

    pic_bus_sequencer #(
        .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC), .HOLD_CYC(HOLD_CYC), .INTA_GAP(INTA_GAP)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4), .ocw1(ocw1),
        .ocw_req(ocw_req), .ocw_a0(ocw_a0), .ocw_data(ocw_data), .ocw_ack(ocw_ack),
        .ack_en(ack_en), .int_in(int_in), .vec(vec), .vec_valid(vec_valid),
        .busy(busy), .init_done(init_done), .cfg_err(cfg_err),
        .CS(CS), .WR(WR), .RD(RD), .A0(A0), .INTA(INTA),
        .D_out(D_out), .D_oe(D_oe), .D_in(D_in), .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Bus monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!WR && wr_prev) act_q.push_back({CS, D_oe, A0, D_out});
        if (!WR) wr_low_cnt <= wr_low_cnt + 1;
        else if (wr_low_cnt > 0) begin
            wid_q.push_back(wr_low_cnt);
            wr_low_cnt <= 0;
        end
        if (!CS && cs_prev) cs_falls <= cs_falls + 1;
        if (!RD) rd_lows <= rd_lows + 1;
        wr_prev <= WR;
        cs_prev <= CS;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: the init word list follows from icw1 bits alone; each write costs WR_LEN cycles.
    task automatic run_init(input logic [7:0] w1, w2, w3, w4, o1);
        int n, c;
        exp_q.delete();
        exp_q.push_back({2'b01, 1'b0, w1 | 8'h10});
        exp_q.push_back({2'b01, 1'b1, w2});
        if (!w1[1]) exp_q.push_back({2'b01, 1'b1, w3});
        if (w1[0])  exp_q.push_back({2'b01, 1'b1, w4});
        exp_q.push_back({2'b01, 1'b1, o1});
        n = exp_q.size();
        @(negedge clk);
        act_q.delete();
        wid_q.delete();
        icw1 = w1; icw2 = w2; icw3 = w3; icw4 = w4; ocw1 = o1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        icw1 = $urandom; icw2 = $urandom; icw3 = $urandom; icw4 = $urandom; ocw1 = $urandom;
        chk("init_busy_k1", 32'(busy), 32'd1);
        chk("init_done_low_k1", 32'(init_done), 32'd0);
        chk("init_cs_k1", 32'(CS), 32'd0);
        c = 1;
        while (!init_done && c < WR_LEN * n + 10) begin
            @(negedge clk);
            c++;
        end
        chk("init_done_cycle", 32'(c), 32'(WR_LEN * n + 1));
        chk("init_busy_end", 32'(busy), 32'd0);
        chk("init_cfg_err", 32'(cfg_err), 32'd0);
        chk("init_nwrites", 32'(act_q.size()), 32'(n));
        for (int i = 0; i < n && i < act_q.size(); i++)
            chk($sformatf("init_write%0d", i), 32'(act_q[i]), 32'(exp_q[i]));
        for (int i = 0; i < wid_q.size(); i++)
            chk($sformatf("init_wr_width%0d", i), 32'(wid_q[i]), 32'(PULSE_CYC));
    endtask

    task automatic run_inta(input logic [7:0] v);
        logic [7:0] hist, busy_h;
        int vv, bad_pins;
        logic busy_after;
        vv = 0; bad_pins = 0; hist = 8'h00; busy_h = 8'h00; busy_after = 1'b1;
        ack_en = 1'b1; int_in = 1'b1; D_in = ~v;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c <= 8) begin
                hist[8 - c]   = INTA;
                busy_h[8 - c] = busy;
            end
            if (c == 9) busy_after = busy;
            if (vec_valid) vv++;
            if (!CS || D_oe) bad_pins++;
            if (c == 1) int_in = 1'b0;
            if (c == 6) D_in = v;
            if (c == 7) D_in = ~v;
        end
        ack_en = 1'b0;
        chk("inta_pattern", 32'(hist), 32'h000000CC);
        chk("inta_busy", 32'(busy_h), 32'h000000FF);
        chk("inta_busy_after", 32'(busy_after), 32'd0);
        chk("inta_vec_valid_count", 32'(vv), 32'd1);
        chk("inta_vec", 32'(vec), 32'(v));
        chk("inta_bus_quiet", 32'(bad_pins), 32'd0);
    endtask

    // OCW request, optionally racing an interrupt; checks ordering and ack timing.
    task automatic run_ocw(input logic a0, input logic [7:0] d, input logic with_int);
        int acks, ack_c, first_cs, last_inta, cs0;
        acks = 0; ack_c = 0; first_cs = 0; last_inta = 0; cs0 = cs_falls;
        act_q.delete();
        ack_en = with_int; int_in = with_int;
        ocw_req = 1'b1; ocw_a0 = a0; ocw_data = d;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (INTA) last_inta = c;
            if (!CS && first_cs == 0) first_cs = c;
            if (ocw_ack) begin
                acks++;
                ack_c = c;
                ocw_req = 1'b0;
            end
            if (c == 1) int_in = 1'b0;
        end
        ocw_req = 1'b0; ack_en = 1'b0;
        chk("ocw_ack_count", 32'(acks), 32'd1);
        chk("ocw_cs_falls", 32'(cs_falls - cs0), 32'd1);
        chk("ocw_ack_in_rel", 32'(ack_c), 32'(first_cs + WR_LEN - 1));
        chk("ocw_write", 32'(act_q.size() > 0 ? act_q[0] : 11'h7FF), 32'({2'b01, a0, d}));
        if (with_int)
            chk("arb_inta_first", 32'(last_inta > 0 && first_cs > last_inta), 32'd1);
    endtask

    task automatic run_reject(input logic [7:0] d);
        int acks, ack_c, cs0;
        acks = 0; ack_c = 0; cs0 = cs_falls;
        ocw_req = 1'b1; ocw_a0 = 1'b0; ocw_data = d | 8'h10;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (ocw_ack) begin
                acks++;
                ack_c = c;
                ocw_req = 1'b0;
            end
        end
        ocw_req = 1'b0;
        chk("rej_ack_count", 32'(acks), 32'd1);
        chk("rej_ack_cycle", 32'(ack_c), 32'd1);
        chk("rej_no_cs", 32'(cs_falls - cs0), 32'd0);
        chk("rej_cfg_err", 32'(cfg_err), 32'd1);
    endtask

    initial begin
        int acks, cs0;
        logic [7:0] w;
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pins", 32'({CS, WR, RD, A0, INTA, D_oe}), 32'b111000);
        chk("rst_status", 32'({busy, init_done, cfg_err, vec_valid, ocw_ack}), 32'd0);
        chk("rst_data", 32'({D_out, vec}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // OCW before init stays pending with no ack and no bus activity
        acks = 0; cs0 = cs_falls;
        ocw_req = 1'b1; ocw_a0 = 1'b1; ocw_data = 8'h33;
        repeat (12) begin
            @(negedge clk);
            if (ocw_ack) acks++;
        end
        ocw_req = 1'b0;
        chk("pre_init_no_ack", 32'(acks), 32'd0);
        chk("pre_init_no_cs", 32'(cs_falls - cs0), 32'd0);

        run_init(8'h1B, 8'hA8, 8'h5A, 8'h02, 8'h80);
        run_init(8'h19, 8'($urandom), 8'h02, 8'($urandom), 8'($urandom));
        for (int i = 0; i < 4; i++)
            run_init(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

        run_inta(8'hAB);
        for (int i = 0; i < 3; i++) run_inta(8'($urandom));

        run_ocw(1'b1, 8'h55, 1'b1);
        for (int i = 0; i < 3; i++) begin
            w = 8'($urandom);
            if (i == 0) w[4] = 1'b0;
            run_ocw(i == 0 ? 1'b0 : 1'b1, w, 1'b0);
        end

        run_reject(8'h10);
        run_init(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        run_reject(8'($urandom));
        run_init(8'h13, 8'h40, 8'h00, 8'h01, 8'hFF);

        // Reset during the WR strobe of ICW2, then replay from ICW1
        icw1 = 8'h1B; icw2 = 8'hA8; icw4 = 8'h02; ocw1 = 8'h80;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 2; c <= WR_LEN + SETUP_CYC + 1; c++) @(negedge clk);
        chk("mid_icw2_strobe", 32'({WR, CS, A0, D_out}), 32'({1'b0, 1'b0, 1'b1, 8'hA8}));
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_pins", 32'({WR, CS, D_oe, busy, init_done}), 32'b11000);
        reset = 1'b0;
        run_init(8'h1B, 8'hA8, 8'h77, 8'h02, 8'h80);

        chk("rd_never_low", 32'(rd_lows), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
